// File: rtl/uart_tx.sv
// uart_tx: UART transmitter for result bytes. Sends 8N1 frames by default.
// Define UART_TX_PARITY_EN to add an even-parity bit, giving an 11-bit frame.
// tx_done rises when the stop bit ends and stays high until the next accepted
// request. TX and tx_done come straight from flops.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line high, waiting for trmt
// TRANSMIT | shifting the frame out, one bit per BAUD_DIV clocks
module uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  TRANSMIT  = 1'b1;
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(FRAME_BITS - 1);

    logic [0:0]            state;
    logic [11:0]           baud_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_load;
    logic                  accept;
    logic                  baud_wrap;
    logic                  frame_end;

    // Frame image as it leaves the line, LSB first: start, data, [parity], stop.
    always_comb begin
`ifdef UART_TX_PARITY_EN
        frame_load = {1'b1, ^tx_data, tx_data, 1'b0};
`else
        frame_load = {1'b1, tx_data, 1'b0};
`endif
    end

    // Bit-boundary and frame-boundary strobes; a request is honoured only in IDLE.
    always_comb begin
        accept    = (state == IDLE) && trmt;
        baud_wrap = (state == TRANSMIT) && (baud_cnt == BAUD_LAST);
        frame_end = baud_wrap && (bit_cnt == BIT_LAST);
    end

    // Two-state sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (accept) begin
            state <= TRANSMIT;
        end else if (frame_end) begin
            state <= IDLE;
        end
    end

    // Baud counter runs 0..BAUD_DIV-1 per bit; bit counter counts finished bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (accept) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else if (state == TRANSMIT) begin
            baud_cnt <= baud_cnt + 12'd1;
        end
    end

    // Shift register drives the line; ones fill in so it idles high after the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '1;
        end else if (accept) begin
            shreg <= frame_load;
        end else if (baud_wrap) begin
            shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
        end
    end

    // Completion flag: set at the end of the stop bit, cleared by the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done <= 1'b0;
        end else if (accept) begin
            tx_done <= 1'b0;
        end else if (frame_end) begin
            tx_done <= 1'b1;
        end
    end

    assign TX = shreg[0];

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. A frame-level model predicts
// TX and tx_done on every clock. Directed sequences pin the model with
// hand-computed literals. A randomized phase then exercises request timing.
module tb_uart_tx;

    localparam int B = 434;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX;
    logic       tx_done;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    uart_tx #(.BAUD_DIV(B)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trmt(trmt),
        .tx_data(tx_data),
        .TX(TX),
        .tx_done(tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as sent on the line, index = bit time.
    function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
        logic [FB-1:0] f;
        logic          par;
        par  = 1'b0;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            par    = par ^ d[i];
        end
`ifdef UART_TX_PARITY_EN
        f[9] = par;
`endif
        f[FB-1] = 1'b1;
        return f;
    endfunction

    // Model: time since accept determines which frame bit is on the line.
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    int            m_t = 0;
    logic [FB-1:0] m_frame = '1;
    logic          exp_tx;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_busy) begin
            m_t++;
            if (m_t == FB * B) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (trmt) begin
            m_busy  = 1'b1;
            m_t     = 0;
            m_frame = frame_of(tx_data);
            m_done  = 1'b0;
        end
        #1;
        if (rst_n) begin
            exp_tx = m_busy ? m_frame[m_t / B] : 1'b1;
            check("tx_line", {31'd0, TX}, {31'd0, exp_tx});
            check("tx_done", {31'd0, tx_done}, {31'd0, m_done});
        end
    end

    // Request for one clock; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] d);
        @(negedge clk);
        trmt    = 1'b1;
        tx_data = d;
        @(negedge clk);
        trmt    = 1'b0;
    endtask

    // Mid-bit samples of the frame; call within the clock following the accept edge.
    task automatic sample_frame(output logic [FB-1:0] bits);
        repeat (B / 2) @(posedge clk);
        #2;
        bits[0] = TX;
        for (int k = 1; k < FB; k++) begin
            repeat (B) @(posedge clk);
            #2;
            bits[k] = TX;
        end
    endtask

    // Continues from the last mid-bit sample; pins the exact completion edge.
    task automatic finish_frame(input string name);
        repeat (B - B / 2 - 1) @(posedge clk);
        #2;
        check({name, "_done_early"}, {31'd0, tx_done}, 32'd0);
        @(posedge clk);
        #2;
        check({name, "_done_edge"}, {31'd0, tx_done}, 32'd1);
        check({name, "_line_idle"}, {31'd0, TX}, 32'd1);
    endtask

    logic [FB-1:0] bits;
    logic [FB-1:0] bits2;
    logic [FB-1:0] exp_a5;

    initial begin
`ifdef UART_TX_PARITY_EN
        exp_a5 = 11'b1_0_10100101_0;
`else
        exp_a5 = 10'b1_10100101_0;
`endif
        // Reset and long idle.
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, TX}, 32'd1);
        check("reset_done", {31'd0, tx_done}, 32'd0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_tx", {31'd0, TX}, 32'd1);
        check("idle_done", {31'd0, tx_done}, 32'd0);

        // Single byte 0xA5.
        send(8'hA5);
        sample_frame(bits);
        check("a5_frame", {{(32-FB){1'b0}}, bits}, {{(32-FB){1'b0}}, exp_a5});
        finish_frame("a5");
        repeat (50) @(negedge clk);
        check("a5_done_held", {31'd0, tx_done}, 32'd1);

        // Busy ignore: request 0xFF 2000 clocks into a 0x3C frame.
        send(8'h3C);
        fork
            sample_frame(bits);
            begin
                repeat (1999) @(negedge clk);
                trmt    = 1'b1;
                tx_data = 8'hFF;
                @(negedge clk);
                trmt    = 1'b0;
            end
        join
        check("busy_data", {24'd0, bits[8:1]}, 32'h3C);
        finish_frame("busy");
        repeat (300) @(negedge clk);
        check("busy_one_frame_done", {31'd0, tx_done}, 32'd1);
        check("busy_one_frame_line", {31'd0, TX}, 32'd1);

        // Back-to-back with trmt held high.
        @(negedge clk);
        trmt    = 1'b1;
        tx_data = 8'h00;
        @(negedge clk);
        tx_data = 8'hFF;
        sample_frame(bits);
        check("b2b_first", {24'd0, bits[8:1]}, 32'h00);
        finish_frame("b2b");
        @(posedge clk);
        #2;
        check("b2b_second_start", {31'd0, TX}, 32'd0);
        check("b2b_done_cleared", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        trmt = 1'b0;
        sample_frame(bits2);
        check("b2b_second", {24'd0, bits2[8:1]}, 32'hFF);
        finish_frame("b2b2");

        // Reset 1500 clocks into a 0x00 frame, then a clean 0x81 frame.
        send(8'h00);
        repeat (1500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", {31'd0, TX}, 32'd1);
        check("midrst_done", {31'd0, tx_done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h81);
        sample_frame(bits);
        check("after_rst_frame", {{(32-FB){1'b0}}, bits}, {{(32-FB){1'b0}}, frame_of(8'h81)});
        check("after_rst_data", {24'd0, bits[8:1]}, 32'h81);
        finish_frame("after_rst");

`ifdef UART_TX_PARITY_EN
        send(8'h01);
        sample_frame(bits);
        check("parity_01", {31'd0, bits[9]}, 32'd1);
        finish_frame("parity");
`endif

        // Randomized request timing and data.
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            trmt    = ($urandom_range(0, 99) < 3);
            tx_data = 8'($urandom);
        end
        @(negedge clk);
        trmt = 1'b0;
        repeat (FB * B + 10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drains the result bytes produced by `cnn_core` back to the host over the DE0-Nano GPIO TX pin. It accepts one byte per `trmt` request on `tx_data` and serialises it as 8N1 (start bit, 8 data bits LSB first, stop bit). It reports frame completion on `tx_done`, which the core's layers use as their transmit-complete handshake.

## Interface
Parameters:
- `BAUD_DIV`, default 434: clocks per bit (50 MHz / 115200 baud). Legal range 16..4095.

Ports:
- `clk`  in  1  system clock, 50 MHz. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trmt`  in  1  transmit request; sampled every clock. Acted on only in IDLE.
- `tx_data`  in  8  byte to send; captured on the clock where `trmt` is accepted.
- `TX`  out  1  serial line. Idles high.
- `tx_done`  out  1  frame complete. Set when the stop bit ends; held until the next accepted `trmt`.

## Operation
- State machine has two states, IDLE and TRANSMIT. Reset puts it in IDLE.
- **IDLE:**
  - `TX`=1.
  - When `trmt`=1, the block loads a 10-bit shift register with {1, `tx_data`, 0}.
  - It clears `tx_done`, zeroes the baud and bit counters, and goes to TRANSMIT.
- **TRANSMIT:**
  - `TX` = shift register bit 0.
  - The baud counter (12 bits) counts 0..`BAUD_DIV`-1.
  - At `BAUD_DIV`-1 the baud counter wraps to 0, the shift register shifts right with a 1 filled in, and the bit counter (4 bits) increments.
  - When the bit counter reaches 10 (stop bit finished): set `tx_done`, go to IDLE.
- `trmt` asserted during TRANSMIT is ignored. There is no queuing, and `tx_data` changes during TRANSMIT have no effect.
- When `trmt`=1 on the same clock that the frame completes, the FSM is still in TRANSMIT, so that request is ignored. The requester holds `trmt` or re-pulses it; the accept happens on the next clock (IDLE).
- `tx_done` stays high across any number of IDLE cycles. It falls only on the clock that accepts a new `trmt`.
- Reset mid-frame: the frame is aborted. `TX` goes to 1 and `tx_done` to 0 asynchronously, and the state goes to IDLE. No partial stop bit is sent.

## Timing
- Reset values: `TX`=1, `tx_done`=0, state IDLE, both counters 0, shift register all ones.
- Accept on clock edge N means:
  - `TX` goes to 0 (start bit) after edge N.
  - Each bit lasts exactly `BAUD_DIV` clocks.
- Data bit k (k=0..7) occupies clocks N+1+(k+1)·`BAUD_DIV` through N+(k+2)·`BAUD_DIV`.
- Stop bit ends and `tx_done` rises after edge N+10·`BAUD_DIV`. `TX` stays 1 from then on.
- Back-to-back: the minimum spacing between accepts is 10·`BAUD_DIV`+1 clocks.
- `TX` and `tx_done` are registered outputs, with no combinational path from inputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The frame becomes 11 bits: start, 8 data, even-parity bit (XOR of `tx_data`), stop.
  - The shift register widens to 11 bits, and the completion count becomes 11.
  - `tx_done` rises after edge N+11·`BAUD_DIV`.
- Not defined: plain 8N1, 10-bit frame, as above.

## Test plan
- **Reset check:** assert `rst_n`=0, release, idle 1000 clocks. Expect `TX`=1 and `tx_done`=0 throughout.
- **Single byte:** `BAUD_DIV`=434, `tx_data`=0xA5 with a 1-clock `trmt`.
  - Sample `TX` at mid-bit. Expect 0,1,0,1,0,0,1,0,1,1.
  - Expect `tx_done` high exactly 4340 clocks after the accept edge, then held high.
- **Busy ignore:** send 0x3C, pulse `trmt` with `tx_data`=0xFF at clock 2000 of the frame. Expect the line to still carry 0x3C and exactly one frame.
- **Back-to-back:** hold `trmt`=1 continuously with `tx_data`=0x00 then 0xFF.
  - Expect two frames separated by exactly 1 idle-high clock.
  - Expect `tx_done` high for that single clock between frames.
- **Mid-frame reset:** reset at clock 1500 of a 0x00 frame. Expect `TX`=1 immediately and `tx_done`=0. A new `trmt` with 0x81 then produces a correct full frame.
- **Parity (with `UART_TX_PARITY_EN`):**
  - 0xA5 gives parity bit 0, and `tx_done` at 4774 clocks.
  - 0x01 gives parity bit 1.
